// File: rtl/simple_dma_controller_pkg.sv
// Shared types and constants for the simple DMA controller: one-hot FSM states,
// bus widths and the memory byte-enable patterns.
package simple_dma_controller_pkg;

    localparam int ADDR_W = 15;
    localparam int CNT_W  = 16;

    localparam logic [1:0] MEM_WE_WR = 2'b11;
    localparam logic [1:0] MEM_WE_RD = 2'b00;

    typedef enum logic [6:0] {
        IDLE     = 7'b000_0001,
        WAIT_DEV = 7'b000_0010,
        REQ      = 7'b000_0100,
        RDAT     = 7'b000_1000,
        NEXT     = 7'b001_0000,
        GAP      = 7'b010_0000,
        DONE     = 7'b100_0000
    } state_e;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [CNT_W-1:0] byte_addr);
        return byte_addr[CNT_W-1:1];
    endfunction

endpackage

// File: rtl/simple_dma_controller_if.sv
// Device-side job handshake plus openMSP430 DMA master port, bundled as one interface.
// master: the controller's view; slave: the device/memory environment's view.
interface simple_dma_controller_if;
    import simple_dma_controller_pkg::*;

    logic              dma_rqst;
    logic              dma_rd_wr;
    logic [CNT_W-1:0]  dma_start_address;
    logic [CNT_W-1:0]  dma_num_words;
    logic              dev_ack;
    logic [15:0]       dev_out;
    logic [15:0]       dev_in;
    logic              dma_ack;
    logic              dma_end_flag;
    logic              dma_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic              mem_en;
    logic [1:0]        mem_we;
    logic              mem_priority;
    logic              mem_wkup;
    logic [15:0]       mem_dout;
    logic              mem_ready;
    logic              mem_resp;

    modport master (
        input  dma_rqst, dma_rd_wr, dma_start_address, dma_num_words, dev_ack, dev_out,
               mem_dout, mem_ready, mem_resp,
        output dev_in, dma_ack, dma_end_flag, dma_err, mem_addr, mem_din, mem_en, mem_we,
               mem_priority, mem_wkup
    );

    modport slave (
        output dma_rqst, dma_rd_wr, dma_start_address, dma_num_words, dev_ack, dev_out,
               mem_dout, mem_ready, mem_resp,
        input  dev_in, dma_ack, dma_end_flag, dma_err, mem_addr, mem_din, mem_en, mem_we,
               mem_priority, mem_wkup
    );

endinterface

// File: rtl/simple_dma_controller_addr_cnt.sv
// dma_addr_cnt: word address incrementer (15-bit wrap), remaining-word down-counter
// and beats-in-burst counter. Flags reflect the registered values.
module dma_addr_cnt
    import simple_dma_controller_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [CNT_W-1:0]  cnt_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              cnt_zero_o,
    output logic              burst_hit_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       beat_q, beat_d;

    // Next address/count/beat; a full burst restarts the beat count on the following step
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        beat_d = beat_q;
        if (load_i) begin
            addr_d = addr_i;
            cnt_d  = cnt_i;
            beat_d = 16'd0;
        end else if (step_i) begin
            addr_d = addr_q + 15'd1;
            cnt_d  = cnt_q - 16'd1;
            beat_d = burst_hit_o ? 16'd1 : beat_q + 16'd1;
        end else begin
            addr_d = addr_q;
            cnt_d  = cnt_q;
            beat_d = beat_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= 15'd0;
            cnt_q  <= 16'd0;
            beat_q <= 16'd0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            beat_q <= beat_d;
        end
    end

    assign addr_o      = addr_q;
    assign cnt_zero_o  = (cnt_q == 16'd0);
    assign burst_hit_o = (beat_q == 16'(BURST_LEN));

endmodule

// File: rtl/simple_dma_controller.sv
// Executes one device word-transfer job at a time on the openMSP430 DMA master port.
// Optional bus-error abort is enabled by defining SIMPLE_DMA_CTRL_ERR_ABORT_EN.
module simple_dma_controller
    import simple_dma_controller_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4,
    parameter logic        PRIO      = 1'b0
) (
    input  logic                    mclk,
    input  logic                    reset_n,
    simple_dma_controller_if.master bus
);

    state_e            state_q, state_d;
    logic              dir_q, dir_d;
    logic              done_seen_q;
    logic              load_s, step_s, err_set_s, err_clr_s;
    logic              cnt_zero_s, burst_hit_s;
    logic [ADDR_W-1:0] addr_s;
    logic              mem_en_s, dma_ack_s, end_flag_s;
    logic [1:0]        mem_we_s;
    logic [15:0]       mem_din_s, dev_in_s;
    logic              unused_s;

    dma_addr_cnt #(.BURST_LEN(BURST_LEN)) u_addr_cnt (
        .clk_i       (mclk),
        .rst_ni      (reset_n),
        .load_i      (load_s),
        .step_i      (step_s),
        .addr_i      (word_addr(bus.dma_start_address)),
        .cnt_i       (bus.dma_num_words),
        .addr_o      (addr_s),
        .cnt_zero_o  (cnt_zero_s),
        .burst_hit_o (burst_hit_s)
    );

    // State, direction and first-cycle-of-DONE tracking
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            dir_q       <= 1'b0;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            done_seen_q <= (state_q == DONE);
        end
    end

    // Next state and bus outputs
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        load_s     = 1'b0;
        step_s     = 1'b0;
        err_set_s  = 1'b0;
        err_clr_s  = 1'b0;
        mem_en_s   = 1'b0;
        mem_we_s   = MEM_WE_RD;
        mem_din_s  = 16'd0;
        dev_in_s   = 16'd0;
        dma_ack_s  = 1'b0;
        end_flag_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dma_rqst) begin
                    load_s    = 1'b1;
                    err_clr_s = 1'b1;
                    dir_d     = bus.dma_rd_wr;
                    state_d   = (bus.dma_num_words == 16'd0) ? DONE : WAIT_DEV;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_DEV: begin
                if (!bus.dma_rqst)    state_d = IDLE;
                else if (bus.dev_ack) state_d = REQ;
                else                  state_d = WAIT_DEV;
            end
            REQ: begin
                mem_en_s = 1'b1;
                if (!dir_q) begin
                    mem_we_s  = MEM_WE_WR;
                    mem_din_s = bus.dev_out;
                end else begin
                    mem_we_s  = MEM_WE_RD;
                end
                if (bus.mem_ready) begin
                    if (!dir_q) begin
                        dma_ack_s = 1'b1;
                        step_s    = 1'b1;
                        state_d   = NEXT;
                    end else begin
                        state_d   = RDAT;
                    end
                end else begin
                    state_d = REQ;
                end
            end
            RDAT: begin
                dev_in_s = bus.mem_dout;
`ifdef SIMPLE_DMA_CTRL_ERR_ABORT_EN
                if (bus.mem_resp) begin
                    err_set_s = 1'b1;
                    state_d   = DONE;
                end else begin
                    dma_ack_s = 1'b1;
                    step_s    = 1'b1;
                    state_d   = NEXT;
                end
`else
                dma_ack_s = 1'b1;
                step_s    = 1'b1;
                state_d   = NEXT;
`endif
            end
            NEXT: begin
`ifdef SIMPLE_DMA_CTRL_ERR_ABORT_EN
                // A write's bus response arrives here, one cycle after its accept
                if (!dir_q && bus.mem_resp) begin
                    err_set_s = 1'b1;
                    state_d   = DONE;
                end else
`endif
                if (cnt_zero_s)         state_d = DONE;
                else if (!bus.dma_rqst) state_d = IDLE;
                else if (burst_hit_s)   state_d = GAP;
                else                    state_d = WAIT_DEV;
            end
            GAP: begin
                state_d = WAIT_DEV;
            end
            DONE: begin
                end_flag_s = !done_seen_q;
                if (!bus.dma_rqst) state_d = IDLE;
                else               state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef SIMPLE_DMA_CTRL_ERR_ABORT_EN
    logic err_q;

    // Sticky bus error, cleared when the next job is latched
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n)       err_q <= 1'b0;
        else if (err_clr_s) err_q <= 1'b0;
        else if (err_set_s) err_q <= 1'b1;
        else                err_q <= err_q;
    end

    assign bus.dma_err = err_q;
    assign unused_s    = bus.dma_start_address[0];
`else
    assign bus.dma_err = 1'b0;
    assign unused_s    = ^{bus.dma_start_address[0], bus.mem_resp, err_set_s, err_clr_s};
`endif

    assign bus.mem_en       = mem_en_s;
    assign bus.mem_addr     = mem_en_s ? addr_s : 15'd0;
    assign bus.mem_we       = mem_we_s;
    assign bus.mem_din      = mem_din_s;
    assign bus.mem_priority = mem_en_s & PRIO;
    assign bus.mem_wkup     = (state_q != IDLE);
    assign bus.dev_in       = dev_in_s;
    assign bus.dma_ack      = dma_ack_s;
    assign bus.dma_end_flag = end_flag_s;

endmodule
